// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encoding, register-zero constant and counter widths.
package pipeline_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         STALL_CNT_W = 16;
    localparam int         MDU_CNT_W   = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of hazard inputs from the datapath and stall/flush controls back to it.
// The datapath side is the master; the hazard controller is the slave.
interface pipeline_hazard_ctrl_if
    import pipeline_pkg::*;
#(
    parameter int REG_W = 5
);

    logic                   IDEX_MemRead;
    logic [REG_W-1:0]       IDEX_Rt;
    logic [REG_W-1:0]       IFID_Rs;
    logic [REG_W-1:0]       IFID_Rt;
    logic                   IFID_UsesRt;
    logic                   BranchTaken;
    logic                   MDU_Start;

    logic                   PCWrite;
    logic                   IFID_WriteEnable;
    logic                   IFID_Flush;
    logic                   IDEX_Flush;
    logic                   MDU_Busy;
    logic [STALL_CNT_W-1:0] StallCycles;

    modport master (
        output IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt, BranchTaken, MDU_Start,
        input  PCWrite, IFID_WriteEnable, IFID_Flush, IDEX_Flush, MDU_Busy, StallCycles
    );

    modport slave (
        input  IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt, BranchTaken, MDU_Start,
        output PCWrite, IFID_WriteEnable, IFID_Flush, IDEX_Flush, MDU_Busy, StallCycles
    );

endinterface

// File: rtl/mdu_stall_counter.sv
// Down-counter that times the front-end freeze after a mult/div issues.
// 'last' flags the final stall cycle so the FSM can return to RUN.
module mdu_stall_counter
    import pipeline_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 load,
    input  logic [MDU_CNT_W-1:0] value,
    input  logic                 decrement,
    output logic                 last,
    output logic                 busy
);

    logic [MDU_CNT_W-1:0] cnt_q;
    logic [MDU_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (decrement && (cnt_q != '0)) begin
            cnt_d = cnt_q - MDU_CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == MDU_CNT_W'(1));
    assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer: load-use stall, mult/div front-end freeze,
// branch flush of IF/ID, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int REG_W       = 5
) (
    input  logic                   Clock,
    input  logic                   Reset,
    pipeline_hazard_ctrl_if.slave  hz
);

    state_e                 state_q;
    state_e                 state_d;
    logic [STALL_CNT_W-1:0] stall_q;
    logic [STALL_CNT_W-1:0] stall_d;

    logic lu;
    logic mdu_load;
    logic mdu_dec;
    logic mdu_last;
    logic mdu_cnt_busy;
    logic pc_write;
    logic ifid_we;
    logic ifid_flush;
    logic idex_flush;
    logic mdu_busy;

    assign lu = hz.IDEX_MemRead
              & (hz.IDEX_Rt != REG_W'(REG_ZERO))
              & ((hz.IDEX_Rt == hz.IFID_Rs) | (hz.IFID_UsesRt & (hz.IDEX_Rt == hz.IFID_Rt)));

    mdu_stall_counter u_mdu_cnt (
        .Clock     (Clock),
        .Reset     (Reset),
        .load      (mdu_load),
        .value     (MDU_CNT_W'(MDU_LATENCY)),
        .decrement (mdu_dec),
        .last      (mdu_last),
        .busy      (mdu_cnt_busy)
    );

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        mdu_busy   = 1'b0;
        mdu_load   = 1'b0;
        mdu_dec    = 1'b0;

        case (state_q)
            ST_RUN: begin
                // A load-use stall wins: the ID operands are stale, so branch and MDU decode are ignored.
                if (lu) begin
                    pc_write   = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                end else begin
                    ifid_flush = hz.BranchTaken;
                    if (hz.MDU_Start && (MDU_LATENCY > 0)) begin
                        state_d  = ST_MDU_WAIT;
                        mdu_load = 1'b1;
                    end
                end
            end
            ST_MDU_WAIT: begin
                pc_write   = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
                mdu_busy   = 1'b1;
                mdu_dec    = 1'b1;
                // An empty counter here can only mean corruption; leave rather than hang.
                if (mdu_last || !mdu_cnt_busy) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (Reset) begin
            pc_write   = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            mdu_busy   = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_write && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_RUN;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    assign hz.PCWrite          = pc_write;
    assign hz.IFID_WriteEnable = ifid_we;
    assign hz.IFID_Flush       = ifid_flush;
    assign hz.IDEX_Flush       = idex_flush;
    assign hz.MDU_Busy         = mdu_busy;
    assign hz.StallCycles      = stall_q;

endmodule
